debounce_multi: RTL and testbench

Parametrised multi-channel pushbutton/switch conditioner for the alarm controller front end. Each of CHANNELS asynchronous inputs passes through its own synchroniser and stability counter. The block produces a clean level, one-cycle rise/fall strobes and a global change strobe per channel. A run-time fast mode shortens the stability window for bench and demo use without re-synthesis.

---
 rtl/debounce_multi.sv | 114 +++++++++++
 tb/tb_debounce_multi.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchroniser + stability counter that turns
// bouncy pushbutton/switch inputs into a clean level, one-cycle rise/fall
// strobes and a shared any_change strobe. A run-time fast mode swaps the
// long stability window for a short one so demos and benches stay quick.
module debounce_multi #(
    parameter int                  CHANNELS      = 6,
    parameter int                  STABLE_CYCLES = 1_000_000,
    parameter int                  FAST_CYCLES   = 16,
    parameter int                  CNT_W         = 20,
    parameter int                  SYNC_STAGES   = 2,
    parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_noisy,
    input  logic                i_fast_mode,
    output logic [CHANNELS-1:0] o_clean,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic                o_any_change
);

    // Counter value at which the candidate is considered stable (T-1).
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAST_LAST   = CNT_W'(FAST_CYCLES - 1);

    logic [CNT_W-1:0]    w_last;
    logic [CHANNELS-1:0] w_rise_next;
    logic [CHANNELS-1:0] w_fall_next;
    logic                r_any_change;

    // Threshold is re-evaluated every cycle so a fast_mode change takes
    // effect immediately, even on a count already in progress.
    always_comb begin
        w_last = i_fast_mode ? FAST_LAST : STABLE_LAST;
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_cand;
            logic                   r_clean;
            logic                   r_rise;
            logic                   r_fall;
            logic [CNT_W-1:0]       r_cnt;
            logic                   w_s;
            logic                   w_update;

            // Metastability guard: shift the raw input through SYNC_STAGES flops.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sync <= {SYNC_STAGES{RESET_VAL[gi]}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], i_noisy[gi]};
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];

            // The candidate has been steady long enough to be published.
            // Uses >= so a threshold shrink mid-count still fires.
            assign w_update = (w_s == r_cand) && (r_cnt >= w_last);

            // Candidate tracking and stability counting; any change restarts
            // the count, the counter never runs past the normal threshold.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cand  <= RESET_VAL[gi];
                    r_cnt   <= '0;
                    r_clean <= RESET_VAL[gi];
                end else if (w_s != r_cand) begin
                    r_cand <= w_s;
                    r_cnt  <= '0;
                end else if (r_cnt >= w_last) begin
                    r_clean <= r_cand;
                end else if (r_cnt < STABLE_LAST) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // Strobes only fire when the published level actually changes.
            assign w_rise_next[gi] = w_update &  r_cand & ~r_clean;
            assign w_fall_next[gi] = w_update & ~r_cand &  r_clean;

            // Register the edge strobes alongside the clean level update.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= w_rise_next[gi];
                    r_fall <= w_fall_next[gi];
                end
            end

            assign o_clean[gi] = r_clean;
            assign o_rise[gi]  = r_rise;
            assign o_fall[gi]  = r_fall;
        end
    endgenerate

    // Single summary pulse, aligned with the per-channel strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |(w_rise_next | w_fall_next);
        end
    end

    assign o_any_change = r_any_change;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (4 channels, T=8 normal / 3 fast).
// Expected output events are queued with the cycle they must appear on;
// every cycle either pops and compares an event or checks quiet outputs.
module tb_debounce_multi;

    localparam int CH     = 4;
    localparam int STABLE = 8;
    localparam int FAST   = 3;
    localparam int SYNC   = 2;
    // Driving just after edge k: first sampling edge is k+1, outputs
    // update at (k+1) + SYNC + T.
    localparam int LAT_N  = 1 + SYNC + STABLE;
    localparam int LAT_F  = 1 + SYNC + FAST;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] noisy;
    logic          fast_mode;
    logic [CH-1:0] clean;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          any_change;

    typedef struct {
        int            cyc;
        string         tag;
        logic [CH-1:0] clean;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          any;
    } exp_t;

    exp_t          sb[$];
    int            cyc;
    int            n_checks;
    int            n_fail;
    logic [CH-1:0] model_clean;
    logic [CH-1:0] exp_clean;

    debounce_multi #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (STABLE),
        .FAST_CYCLES   (FAST),
        .CNT_W         (4),
        .SYNC_STAGES   (SYNC),
        .RESET_VAL     ('0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_noisy      (noisy),
        .i_fast_mode  (fast_mode),
        .o_clean      (clean),
        .o_rise       (rise),
        .o_fall       (fall),
        .o_any_change (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Queue an output event; the clean vector is the bench's running model.
    task automatic push(input int at, input string tag, input logic [CH-1:0] r,
                        input logic [CH-1:0] f);
        exp_t e;
        model_clean = (model_clean | r) & ~f;
        e.cyc   = at;
        e.tag   = tag;
        e.clean = model_clean;
        e.rise  = r;
        e.fall  = f;
        e.any   = |(r | f);
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit after the edge, then compare.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            exp_clean = e.clean;
            chk({e.tag, "_clean"}, 32'(clean), 32'(e.clean));
            chk({e.tag, "_rise"},  32'(rise),  32'(e.rise));
            chk({e.tag, "_fall"},  32'(fall),  32'(e.fall));
            chk({e.tag, "_any"},   32'(any_change), 32'(e.any));
            $display("txn %s cycle %0d clean=%b rise=%b fall=%b any=%b",
                     e.tag, cyc, clean, rise, fall, any_change);
        end else begin
            chk("quiet_clean", 32'(clean), 32'(exp_clean));
            chk("quiet_strobes", 32'({rise, fall, any_change}), 32'(0));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k;
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        model_clean = '0;
        exp_clean   = '0;
        noisy       = '0;
        fast_mode   = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        #1;
        chk("reset_clean", 32'(clean), 32'(0));
        chk("reset_strobes", 32'({rise, fall, any_change}), 32'(0));
        ticks(3);
        rst_n = 1'b1;
        ticks(2);

        // Clean press on channel 0, normal mode.
        k = cyc; noisy[0] = 1'b1;
        push(k + LAT_N, "press0", 4'b0001, 4'b0000);
        ticks(LAT_N + 3);

        // Bounce on channel 1: only the final settled level is reported.
        noisy[1] = 1'b1; ticks(3);
        noisy[1] = 1'b0; ticks(3);
        noisy[1] = 1'b1; ticks(3);
        noisy[1] = 1'b0; ticks(3);
        k = cyc; noisy[1] = 1'b1;
        push(k + LAT_N, "bounce1", 4'b0010, 4'b0000);
        ticks(LAT_N + 3);

        // Glitch on channel 2 shorter than the window: nothing reported.
        noisy[2] = 1'b1; ticks(5);
        noisy[2] = 1'b0; ticks(20);

        // Bring channel 3 high, then release it in fast mode.
        k = cyc; noisy[3] = 1'b1;
        push(k + LAT_N, "press3", 4'b1000, 4'b0000);
        ticks(LAT_N + 3);
        fast_mode = 1'b1;
        k = cyc; noisy[3] = 1'b0;
        push(k + LAT_F, "fastfall3", 4'b0000, 4'b1000);
        ticks(LAT_F + 2);
        fast_mode = 1'b0;
        ticks(12);

        // fast_mode raised while channel 3 counts at 4: fires on that edge.
        k = cyc; noisy[3] = 1'b1;
        ticks(7);
        fast_mode = 1'b1;
        push(k + 8, "midswitch3", 4'b1000, 4'b0000);
        ticks(3);
        fast_mode = 1'b0;
        ticks(3);

        // Release channel 0 so it can rise together with channel 2.
        k = cyc; noisy[0] = 1'b0;
        push(k + LAT_N, "release0", 4'b0000, 4'b0001);
        ticks(LAT_N + 3);
        k = cyc; noisy[0] = 1'b1; noisy[2] = 1'b1;
        push(k + LAT_N, "simul02", 4'b0101, 4'b0000);
        ticks(LAT_N + 3);

        // Channel 1 mid-count when reset hits between clock edges.
        noisy[1] = 1'b0;
        ticks(5);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_clean", 32'(clean), 32'(0));
        chk("async_rst_strobes", 32'({rise, fall, any_change}), 32'(0));
        chk("sb_before_reset", 32'(sb.size()), 32'(0));
        sb.delete();
        model_clean = '0;
        exp_clean   = '0;
        ticks(2);
        // Inputs 0,2,3 differ from the reset level: full-latency rises.
        k = cyc; rst_n = 1'b1;
        push(k + LAT_N, "post_rst", 4'b1101, 4'b0000);
        ticks(LAT_N + 4);

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
